// File: rtl/axis_rr_arbiter_pkg.sv
// rtl/axis_rr_arbiter_pkg.sv - shared types, constants and round-robin pick helper
// Package axis_arb_pkg:
//   arb_state_t  arbiter FSM state (IDLE / LOCKED)
//   SKID_DEPTH   entries in the output skid stage
//   rr_pick()    first valid index at or after ptr, wrapping at n_ports
package axis_arb_pkg;

    typedef enum logic [0:0] {IDLE, LOCKED} arb_state_t;

    localparam int SKID_DEPTH = 2;

    // rr_pick works on a fixed-width request vector so that one function
    // serves every N_PORTS up to MAX_PORTS; unused upper bits are tied to 0.
    localparam int MAX_PORTS  = 16;
    localparam int PICK_IDX_W = 4;

    typedef struct packed {
        logic                  found;
        logic [PICK_IDX_W-1:0] idx;
    } rr_pick_t;

    function automatic rr_pick_t rr_pick(
        input logic [MAX_PORTS-1:0]  valid,
        input logic [PICK_IDX_W-1:0] ptr,
        input logic [PICK_IDX_W:0]   n_ports
    );
        rr_pick_t              res;
        logic [PICK_IDX_W:0]   k;
        res = '0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            k = {1'b0, ptr} + (PICK_IDX_W+1)'(i);
            if (k >= n_ports) begin
                k = k - n_ports;
            end
            if (((PICK_IDX_W+1)'(i) < n_ports) && !res.found && valid[k[PICK_IDX_W-1:0]]) begin
                res.found = 1'b1;
                res.idx   = k[PICK_IDX_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axis_rr_arbiter_if.sv
// rtl/axis_rr_arbiter_if.sv - AXI-Stream N-to-1 arbiter bus bundle
// Signals:
//   s_axis_tdata/tvalid/tlast  N_PORTS packed sources into the arbiter
//   s_axis_tready              per-source ready from the arbiter
//   m_axis_tdata/tlast/tid/tvalid  arbitrated output stream
//   m_axis_tready              sink ready
// Modports: master = arbiter side, slave = surrounding sources and sink.
interface axis_rr_arbiter_if #(
    parameter int N_PORTS  = 4,
    parameter int WIDTH    = 8,
    parameter int ID_WIDTH = $clog2(N_PORTS)
);
    logic [N_PORTS*WIDTH-1:0] s_axis_tdata;
    logic [N_PORTS-1:0]       s_axis_tvalid;
    logic [N_PORTS-1:0]       s_axis_tlast;
    logic [N_PORTS-1:0]       s_axis_tready;
    logic [WIDTH-1:0]         m_axis_tdata;
    logic                     m_axis_tlast;
    logic [ID_WIDTH-1:0]      m_axis_tid;
    logic                     m_axis_tvalid;
    logic                     m_axis_tready;

    modport master (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tlast, m_axis_tid, m_axis_tvalid
    );

    modport slave (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tlast, m_axis_tid, m_axis_tvalid
    );
endinterface

// File: rtl/axis_rr_arbiter_skid.sv
// rtl/axis_rr_arbiter_skid.sv - 2-entry registered skid stage (axis_skid_buffer)
// Ports:
//   clk, rstn                      clock, synchronous active-low reset
//   in_data/in_valid/in_ready      upstream handshake; in_ready is registered
//   out_data/out_valid/out_ready   downstream handshake, driven from registers
module axis_skid_buffer
    import axis_arb_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);
    logic [DATA_W-1:0] mem [SKID_DEPTH];
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        count;
    logic [1:0]        count_next;
    logic              push;
    logic              pop;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 2'd1;
        end else if (!push && pop) begin
            count_next = count - 2'd1;
        end
    end

    // in_ready looks one cycle ahead: it is set from the occupancy after
    // this edge, so ready never depends combinationally on out_ready.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            mem[0]   <= '0;
            mem[1]   <= '0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= 2'd0;
            in_ready <= 1'b1;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count    <= count_next;
            in_ready <= (count_next < 2'(SKID_DEPTH));
        end
    end

    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];
endmodule

// File: rtl/axis_rr_arbiter.sv
// rtl/axis_rr_arbiter.sv - packet-aware round-robin AXI-Stream N-to-1 arbiter
// Ports:
//   clk   clock
//   rstn  synchronous active-low reset
//   bus   axis_rr_arbiter_if.master: N_PORTS sources in, one stream out with tid
// Build option: AXIS_RR_ARBITER_PKT_LOCK_EN keeps the grant until tlast;
//   without it the arbiter re-arbitrates on every beat.
module axis_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter int N_PORTS  = 4,
    parameter int WIDTH    = 8,
    parameter int ID_WIDTH = $clog2(N_PORTS)
) (
    input logic               clk,
    input logic               rstn,
    axis_rr_arbiter_if.master bus
);
    localparam int DATA_W = ID_WIDTH + 1 + WIDTH;

    arb_state_t            state_q, state_d;
    logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
    logic [ID_WIDTH-1:0]   grant;
    logic                  grant_valid;
    logic                  sel_valid;
    logic                  sel_last;
    logic [WIDTH-1:0]      sel_data;
    logic [N_PORTS-1:0]    tready_d;
    logic                  skid_in_valid;
    logic                  skid_in_ready;
    logic                  accept;
    logic [MAX_PORTS-1:0]  valid_ext;
    rr_pick_t              pick;
    logic [DATA_W-1:0]     skid_out_data;
`ifdef AXIS_RR_ARBITER_PKT_LOCK_EN
    logic [ID_WIDTH-1:0]   lock_q, lock_d;
`endif

    always_comb begin
        valid_ext              = '0;
        valid_ext[N_PORTS-1:0] = bus.s_axis_tvalid;
    end

    assign pick = rr_pick(valid_ext, PICK_IDX_W'(ptr_q), (PICK_IDX_W+1)'(N_PORTS));

    // Grant source: search result in IDLE, the held port while LOCKED.
    always_comb begin
        grant       = ID_WIDTH'(pick.idx);
        grant_valid = pick.found;
`ifdef AXIS_RR_ARBITER_PKT_LOCK_EN
        if (state_q == LOCKED) begin
            grant       = lock_q;
            grant_valid = 1'b1;
        end
`endif
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        tready_d  = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (grant == ID_WIDTH'(i)) begin
                sel_valid   = bus.s_axis_tvalid[i];
                sel_last    = bus.s_axis_tlast[i];
                sel_data    = bus.s_axis_tdata[i*WIDTH +: WIDTH];
                tready_d[i] = rstn && grant_valid && skid_in_ready;
            end
        end
    end

    assign bus.s_axis_tready = tready_d;
    assign skid_in_valid     = rstn && grant_valid && sel_valid;
    assign accept            = skid_in_valid && skid_in_ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
`ifdef AXIS_RR_ARBITER_PKT_LOCK_EN
        lock_d  = lock_q;
        if (accept) begin
            if (sel_last) begin
                state_d = IDLE;
                ptr_d   = (grant == ID_WIDTH'(N_PORTS-1)) ? '0 : grant + ID_WIDTH'(1);
            end else begin
                state_d = LOCKED;
                lock_d  = grant;
            end
        end
`else
        if (accept) begin
            ptr_d = (grant == ID_WIDTH'(N_PORTS-1)) ? '0 : grant + ID_WIDTH'(1);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            ptr_q   <= '0;
`ifdef AXIS_RR_ARBITER_PKT_LOCK_EN
            lock_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
`ifdef AXIS_RR_ARBITER_PKT_LOCK_EN
            lock_q  <= lock_d;
`endif
        end
    end

    axis_skid_buffer #(.DATA_W(DATA_W)) u_skid (
        .clk       (clk),
        .rstn      (rstn),
        .in_data   ({grant, sel_last, sel_data}),
        .in_valid  (skid_in_valid),
        .in_ready  (skid_in_ready),
        .out_data  (skid_out_data),
        .out_valid (bus.m_axis_tvalid),
        .out_ready (bus.m_axis_tready)
    );

    assign {bus.m_axis_tid, bus.m_axis_tlast, bus.m_axis_tdata} = skid_out_data;
endmodule

// File: doc/axis_rr_arbiter.md
Name: axis_rr_arbiter

Overview:
- Round-robin arbiter that shares one AXI-Stream sink between N_PORTS AXI-Stream sources, such as a single axis_sync_fifo write port.
- Packet-aware: a granted source keeps the output until its tlast beat is accepted (see Optional Feature).
- The output is registered through a 2-entry skid stage, so no combinational path runs from m_axis_tready to any s_axis_tready.
- Sits directly in front of the shared FIFO, with the source index forwarded on m_axis_tid.

Parameters:
- N_PORTS, 4, number of source ports; must be ≥ 2.
- WIDTH, 8, tdata width per port.
- ID_WIDTH, $clog2(N_PORTS), width of m_axis_tid. Derived; do not override.

Ports:
- clk  in  1  clock, all logic on posedge.
- rstn  in  1  synchronous active-low reset.
- s_axis_tdata  in  N_PORTS*WIDTH  packed source data; port i occupies bits [i*WIDTH +: WIDTH].
- s_axis_tvalid  in  N_PORTS  per-source valid.
- s_axis_tlast  in  N_PORTS  per-source end-of-packet.
- s_axis_tready  out  N_PORTS  per-source ready; at most one bit set per cycle.
- m_axis_tdata  out  WIDTH  output data.
- m_axis_tlast  out  1  output end-of-packet.
- m_axis_tid  out  ID_WIDTH  index of the source that produced the beat.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready from the sink.

Behaviour:
- Reset (rstn=0 at posedge):
  - All m_axis_* outputs go to 0.
  - Skid stage is emptied.
  - FSM goes to IDLE and the rr pointer to 0 (port 0 highest priority).
  - s_axis_tready is all-0 for the whole reset cycle.
  - Reset mid-packet drops the partial packet. No recovery beat is emitted.
- FSM states:
  - IDLE: grant is combinational. It selects the first i with s_axis_tvalid[i]=1, searching from ptr upward with wrap (ptr, ptr+1, …, N_PORTS-1, 0, …).
  - LOCKED: grant = lock_idx regardless of the other valids.
- Ready: s_axis_tready[i] = (i == grant) && grant_valid && skid_in_ready. In IDLE with no valid source, all ready bits are 0.
- Accept: an accepted beat is s_axis_tvalid[g] && s_axis_tready[g].
- Transitions on an accepted beat from port g:
  - tlast=1: go to IDLE and set ptr <= (g+1) mod N_PORTS.
  - tlast=0: go to (or stay in) LOCKED with lock_idx <= g; ptr unchanged.
  - No accept: state held. In LOCKED, a source deasserting tvalid does not release the grant.
- Skid stage (axis_skid_buffer):
  - 2 entries; payload is {tid, tlast, tdata}.
  - skid_in_ready is registered and equals "fewer than 2 entries after this cycle".
  - Latency: a beat accepted at edge k appears on m_axis_* after edge k, i.e. visible in cycle k+1 when the stage was empty.
  - Sustains 1 beat/cycle when m_axis_tready is held at 1.
  - Output holds stable while m_axis_tvalid=1 and m_axis_tready=0 (AXIS rule).
  - Ordering is strictly FIFO.
- Simultaneous push and pop when full: not possible, because skid_in_ready is already 0. A push and pop in the same cycle with 1 entry keeps the count at 1.
- Pointer wrap: ptr = N_PORTS-1 followed by a tlast accept on that port gives ptr = 0.
- Fairness: with all sources continuously valid, packets are granted in order 0,1,2,…,N_PORTS-1,0,…

Optional Feature:
- Macro AXIS_RR_ARBITER_PKT_LOCK_EN.
- Defined: packet lock as described above (LOCKED state in use).
- Undefined:
  - FSM stays in IDLE permanently and re-arbitrates every beat.
  - Every accepted beat advances ptr to g+1.
  - tlast is still carried through to m_axis_tlast unchanged.

Decomposition:
- Package axis_arb_pkg holds:
  - typedef enum logic [0:0] {IDLE, LOCKED} arb_state_t;
  - localparam SKID_DEPTH = 2;
  - function rr_pick(valid, ptr), returning the index and a found flag, shared with the bench reference model.
- Sub-module axis_skid_buffer #(DATA_W) with ports clk, rstn, in_data/in_valid/in_ready, out_data/out_valid/out_ready. Arbiter instantiates it with DATA_W = ID_WIDTH+1+WIDTH.

Test Plan:
- Reset checks:
  - Hold rstn=0 for 3 cycles with all s_axis_tvalid=1 -> all s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0.
  - After release, the first grant goes to port 0.
- Round-robin fairness, PKT_LOCK_EN defined, m_axis_tready=1:
  - Stimulus: all 4 ports send 1-beat packets (tlast=1), port i data = 8'h10+i.
  - Expect m_axis_tid sequence 0,1,2,3,0,… and data 10,11,12,13,10.
  - Expect one beat per cycle after the first 1-cycle latency.
- Packet lock:
  - Stimulus: port 2 sends a 3-beat packet (AA,AB,AC, tlast on AC) while port 0 is valid throughout.
  - Expect AA,AB,AC with tid=2 contiguous; port 0 is granted only after AC is accepted; ptr=3.
- Backpressure:
  - Stimulus: m_axis_tready=0 for 5 cycles during a stream from port 1.
  - Expect the skid to fill to 2 and s_axis_tready[1] to drop to 0.
  - Expect m_axis_tdata/tlast/tid stable throughout.
  - Expect no loss or duplication once tready returns to 1.
- Lock with gap:
  - Stimulus: port 3 asserts tvalid=0 mid-packet for 4 cycles while ports 0-2 are valid.
  - Expect all ready bits for 0-2 to stay at 0 and port 3 to resume.
- Macro undefined:
  - Stimulus: ports 0 and 1 each send 2-beat packets simultaneously.
  - Expect output tid interleaved 0,1,0,1; tlast set only on the second beat of each port.
